xrv1_iqueue_mw: RTL and testbench
=================================

Name: xrv1_iqueue_mw

Overview:
- Multi-issue, completion-tracking instruction queue (scoreboard) for the xrv1 ucore; successor to the single-issue in-order queue.
- Accepts up to ISSUE_W_P instructions per cycle and allocates consecutive itags.
- Tracks out-of-order completion from COMPL_W_P writeback ports and retires up to RETIRE_W_P completed head entries per cycle, in order.
- Supports a full pipeline flush. Exposes per-entry RAW hazard vectors, including intra-bundle hazards, to the issue stage.

Parameters:
- RF_ADDR_WIDTH_P, 5, register-file address width.
- ITAG_WIDTH_P, 3, itag width; depth DEPTH_LP = 2**ITAG_WIDTH_P.
- ISSUE_W_P, 2, issue lanes; lane 0 is oldest.
- COMPL_W_P, 2, completion ports.
- RETIRE_W_P, 2, maximum retires per cycle; must be <= DEPTH_LP.
- NUM_RS_P, 2, source operands per lane.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- flush_i  in  1  discard all entries
- issue_vld_i  in  ISSUE_W_P  lane valid; contiguous from lane 0
- issue_rdy_o  out  1  free entries >= ISSUE_W_P
- issue_rd_vld_i  in  ISSUE_W_P  lane writes rd
- issue_rd_addr_i  in  ISSUE_W_P x RF_ADDR_WIDTH_P  lane rd
- issue_rs_vld_i  in  ISSUE_W_P x NUM_RS_P  source valid
- issue_rs_addr_i  in  ISSUE_W_P x NUM_RS_P x RF_ADDR_WIDTH_P  source address
- issue_itag_o  out  ISSUE_W_P x ITAG_WIDTH_P  itag allocated to each lane
- compl_vld_i  in  COMPL_W_P  completion strobe
- compl_itag_i  in  COMPL_W_P x ITAG_WIDTH_P  completing itag
- retire_vld_o  out  RETIRE_W_P  retire slot valid; contiguous from slot 0
- retire_itag_o  out  RETIRE_W_P x ITAG_WIDTH_P  retiring itag
- retire_rd_vld_o  out  RETIRE_W_P  retiring entry writes rd
- retire_rd_addr_o  out  RETIRE_W_P x RF_ADDR_WIDTH_P  retiring rd
- rs_conflict_o  out  ISSUE_W_P x NUM_RS_P x DEPTH_LP  source hits a live entry's rd
- rs_bundle_conflict_o  out  ISSUE_W_P x NUM_RS_P  source hits an older lane's rd in the same bundle
- count_o  out  ITAG_WIDTH_P+1  occupied entries
- compl_err_o  out  1  registered; completion addressed an invalid or already-done entry

Behaviour:
- State per entry: vld, done, rd_vld, rd_addr. Also head_ptr and tail_ptr (ITAG_WIDTH_P bits, natural wrap) and count (ITAG_WIDTH_P+1 bits).
- Reset (asynchronous): all vld/done/rd_vld = 0, pointers = 0, count = 0, compl_err_o = 0.
  - Resulting outputs: issue_rdy_o = 1, retire_vld_o = 0, count_o = 0, all conflicts = 0.
- Issue:
  - Fires when issue_rdy_o & issue_vld_i[0]. All valid lanes are accepted together.
  - Lane k gets itag tail_ptr + k. issue_itag_o is valid regardless of vld.
  - Entry written with vld = 1, done = 0, rd fields. tail_ptr advances by popcount(issue_vld_i).
  - issue_rdy_o depends only on registered count and is independent of issue_vld_i.
  - A non-contiguous issue_vld_i is illegal; simulation assertion.
- Completion:
  - Sets done on the addressed entry at the next edge if that entry is vld & ~done.
  - Otherwise the completion is ignored and compl_err_o pulses 1 the next cycle.
  - Two ports naming the same itag in one cycle: legal, single set, no error.
- Retire:
  - Combinational from registered state. Slot s is valid iff entries head..head+s are all vld & done.
  - Every valid slot retires at the clock edge: entries cleared, head_ptr += n, count -= n.
  - No retire_rdy; the consumer must accept.
  - A completion in cycle t makes the entry retire-visible in cycle t+1. No same-cycle bypass.
- Simultaneous events: issue and retire in the same cycle give count += issued - retired. Space freed by retire is not usable by an issue in the same cycle.
- Flush:
  - Has priority over issue, completion, and retire in the same cycle.
  - retire_vld_o is forced to 0 combinationally while flush_i = 1.
  - Next state: all entries invalid, head = tail = 0, count = 0.
  - compl_err_o is not raised for completions dropped by a flush.
- rs_conflict_o[k][r][e] = issue_rs_vld_i[k][r] & vld[e] & rd_vld[e] & (rs_addr == rd_addr[e]).
  - done is not masked, because the result is not committed until retire. The issue stage ORs the vector.
- rs_bundle_conflict_o[k][r] = OR over lanes j<k of (issue_vld_i[j] & issue_rd_vld_i[j] & issue_rd_addr_i[j] == rs_addr). Always 0 for lane 0.
- Register x0 receives no special treatment; the decoder clears rd_vld for x0.
- Full: count = DEPTH_LP → issue_rdy_o = 0. Pointers wrap modulo DEPTH_LP; vld bits disambiguate full from empty.

Test Plan:
- After reset, issue lanes 0,1 with rd x3,x4 → itags 0,1; count_o = 2 next cycle; rs_conflict_o[0][0] shows bits 0 and 1 set only for rs = x3 and rs = x4 respectively.
- Issue 4 pairs (DEPTH 8) → count_o = 8, issue_rdy_o = 0. Complete itag 1 only → no retire. Complete itag 0 → next cycle retire_vld_o = 2'b11 with itags 0,1; count_o = 6 after.
- Wrap: issue/retire until head = 7. Complete itags 7 and 0 in the same cycle → retire slots show itags 7,0 with correct rd.
- Same-bundle hazard: lane 0 rd = x5, lane 1 rs0 = x5 → rs_bundle_conflict_o[1][0] = 1, [0][0] = 0.
- Complete an invalid itag, and separately complete an already-done itag → compl_err_o = 1 for one cycle each; state unchanged.
- Flush with 5 entries, a concurrent issue and a concurrent completion → retire_vld_o = 0 that cycle; next cycle count_o = 0, issue_rdy_o = 1, issue_itag_o[0] = 0. Assert rst_i mid-stream → outputs return to reset values immediately without a clock.

Source files
------------

// File: rtl/xrv1_iqueue_mw.sv
// xrv1_iqueue_mw: multi-issue instruction queue for the xrv1 ucore.
// Instructions are accepted in bundles and given consecutive itags. The queue
// records out-of-order completions, retires the oldest run of completed
// entries in order, and tells the issue stage about RAW hazards.
module xrv1_iqueue_mw #(
    parameter  int RF_ADDR_WIDTH_P = 5,
    parameter  int ITAG_WIDTH_P    = 3,
    parameter  int ISSUE_W_P       = 2,
    parameter  int COMPL_W_P       = 2,
    parameter  int RETIRE_W_P      = 2,
    parameter  int NUM_RS_P        = 2,
    localparam int DEPTH_LP        = 2**ITAG_WIDTH_P
) (
    input  logic                                                   clk_i,
    input  logic                                                   rst_i,
    input  logic                                                   flush_i,
    input  logic [ISSUE_W_P-1:0]                                   issue_vld_i,
    output logic                                                   issue_rdy_o,
    input  logic [ISSUE_W_P-1:0]                                   issue_rd_vld_i,
    input  logic [ISSUE_W_P-1:0][RF_ADDR_WIDTH_P-1:0]              issue_rd_addr_i,
    input  logic [ISSUE_W_P-1:0][NUM_RS_P-1:0]                     issue_rs_vld_i,
    input  logic [ISSUE_W_P-1:0][NUM_RS_P-1:0][RF_ADDR_WIDTH_P-1:0] issue_rs_addr_i,
    output logic [ISSUE_W_P-1:0][ITAG_WIDTH_P-1:0]                 issue_itag_o,
    input  logic [COMPL_W_P-1:0]                                   compl_vld_i,
    input  logic [COMPL_W_P-1:0][ITAG_WIDTH_P-1:0]                 compl_itag_i,
    output logic [RETIRE_W_P-1:0]                                  retire_vld_o,
    output logic [RETIRE_W_P-1:0][ITAG_WIDTH_P-1:0]                retire_itag_o,
    output logic [RETIRE_W_P-1:0]                                  retire_rd_vld_o,
    output logic [RETIRE_W_P-1:0][RF_ADDR_WIDTH_P-1:0]             retire_rd_addr_o,
    output logic [ISSUE_W_P-1:0][NUM_RS_P-1:0][DEPTH_LP-1:0]       rs_conflict_o,
    output logic [ISSUE_W_P-1:0][NUM_RS_P-1:0]                     rs_bundle_conflict_o,
    output logic [ITAG_WIDTH_P:0]                                  count_o,
    output logic                                                   compl_err_o
);

    // Issue is only offered when a full bundle is guaranteed to fit.
    localparam logic [ITAG_WIDTH_P:0] RDY_MAX_LP = (ITAG_WIDTH_P+1)'(DEPTH_LP - ISSUE_W_P);

    logic [DEPTH_LP-1:0]                      vld_reg, vld_next;
    logic [DEPTH_LP-1:0]                      done_reg, done_next;
    logic [DEPTH_LP-1:0]                      rd_vld_reg, rd_vld_next;
    logic [DEPTH_LP-1:0][RF_ADDR_WIDTH_P-1:0] rd_addr_reg, rd_addr_next;
    logic [ITAG_WIDTH_P-1:0]                  head_ptr_reg, head_ptr_next;
    logic [ITAG_WIDTH_P-1:0]                  tail_ptr_reg, tail_ptr_next;
    logic [ITAG_WIDTH_P:0]                    count_reg, count_next;
    logic                                     compl_err_reg, compl_err_next;

    logic                         issue_fire;
    logic [ITAG_WIDTH_P:0]        issue_cnt, retire_cnt;
    logic [RETIRE_W_P-1:0]        retire_ok, retire_chain;
    logic [COMPL_W_P-1:0]         compl_ok, compl_bad;
    logic [ITAG_WIDTH_P-1:0]      wr_idx;
    logic                         run;

    assign issue_rdy_o = (count_reg <= RDY_MAX_LP);
    assign issue_fire  = issue_rdy_o & issue_vld_i[0];
    assign count_o     = count_reg;
    assign compl_err_o = compl_err_reg;

    genvar gi, gr, ge;

    // Itags handed to the issue lanes; lane k gets tail + k.
    generate
        for (gi = 0; gi < ISSUE_W_P; gi++) begin : g_itag
            assign issue_itag_o[gi] = tail_ptr_reg + ITAG_WIDTH_P'(gi);
        end
    endgenerate

    // Per-slot readiness of the entries at the head of the queue.
    generate
        for (gi = 0; gi < RETIRE_W_P; gi++) begin : g_retire
            logic [ITAG_WIDTH_P-1:0] slot_idx;
            assign slot_idx             = head_ptr_reg + ITAG_WIDTH_P'(gi);
            assign retire_ok[gi]        = vld_reg[slot_idx] & done_reg[slot_idx];
            assign retire_vld_o[gi]     = retire_chain[gi] & ~flush_i;
            assign retire_itag_o[gi]    = slot_idx;
            assign retire_rd_vld_o[gi]  = rd_vld_reg[slot_idx];
            assign retire_rd_addr_o[gi] = rd_addr_reg[slot_idx];
        end
    endgenerate

    // A slot retires only when every older slot in this cycle also retires.
    always_comb begin
        retire_chain = '0;
        run          = 1'b1;
        for (int s = 0; s < RETIRE_W_P; s++) begin
            run             = run & retire_ok[s];
            retire_chain[s] = run;
        end
    end

    // Completions are accepted only for live, not-yet-done entries.
    generate
        for (gi = 0; gi < COMPL_W_P; gi++) begin : g_compl
            assign compl_ok[gi]  = compl_vld_i[gi] & vld_reg[compl_itag_i[gi]] & ~done_reg[compl_itag_i[gi]];
            assign compl_bad[gi] = compl_vld_i[gi] & ~(vld_reg[compl_itag_i[gi]] & ~done_reg[compl_itag_i[gi]]);
        end
    endgenerate

    // Source operands against every live entry's destination.
    generate
        for (gi = 0; gi < ISSUE_W_P; gi++) begin : g_conf_lane
            for (gr = 0; gr < NUM_RS_P; gr++) begin : g_conf_rs
                for (ge = 0; ge < DEPTH_LP; ge++) begin : g_conf_ent
                    assign rs_conflict_o[gi][gr][ge] = issue_rs_vld_i[gi][gr] & vld_reg[ge] & rd_vld_reg[ge]
                                                     & (issue_rs_addr_i[gi][gr] == rd_addr_reg[ge]);
                end
            end
        end
    endgenerate

    // Source operands against destinations of older lanes in the same bundle.
    always_comb begin
        rs_bundle_conflict_o = '0;
        for (int k = 1; k < ISSUE_W_P; k++) begin
            for (int r = 0; r < NUM_RS_P; r++) begin
                for (int j = 0; j < k; j++) begin
                    if (issue_vld_i[j] && issue_rd_vld_i[j] && (issue_rd_addr_i[j] == issue_rs_addr_i[k][r]))
                        rs_bundle_conflict_o[k][r] = 1'b1;
                end
            end
        end
    end

    // Number of lanes presented and number of slots retiring this cycle.
    always_comb begin
        issue_cnt  = '0;
        retire_cnt = '0;
        for (int k = 0; k < ISSUE_W_P; k++)
            issue_cnt = issue_cnt + (ITAG_WIDTH_P+1)'(issue_vld_i[k]);
        for (int s = 0; s < RETIRE_W_P; s++)
            retire_cnt = retire_cnt + (ITAG_WIDTH_P+1)'(retire_vld_o[s]);
    end

    // Next-state: retire clears, completion marks done, issue fills; flush wins.
    always_comb begin
        vld_next       = vld_reg;
        done_next      = done_reg;
        rd_vld_next    = rd_vld_reg;
        rd_addr_next   = rd_addr_reg;
        head_ptr_next  = head_ptr_reg + retire_cnt[ITAG_WIDTH_P-1:0];
        tail_ptr_next  = tail_ptr_reg;
        count_next     = count_reg - retire_cnt;
        compl_err_next = |compl_bad;
        wr_idx         = '0;

        for (int s = 0; s < RETIRE_W_P; s++) begin
            if (retire_vld_o[s]) begin
                wr_idx              = head_ptr_reg + ITAG_WIDTH_P'(s);
                vld_next[wr_idx]    = 1'b0;
                done_next[wr_idx]   = 1'b0;
                rd_vld_next[wr_idx] = 1'b0;
            end
        end

        for (int c = 0; c < COMPL_W_P; c++) begin
            if (compl_ok[c])
                done_next[compl_itag_i[c]] = 1'b1;
        end

        // Issue slots are always free here: readiness leaves room for a full bundle.
        if (issue_fire) begin
            for (int k = 0; k < ISSUE_W_P; k++) begin
                if (issue_vld_i[k]) begin
                    wr_idx               = tail_ptr_reg + ITAG_WIDTH_P'(k);
                    vld_next[wr_idx]     = 1'b1;
                    done_next[wr_idx]    = 1'b0;
                    rd_vld_next[wr_idx]  = issue_rd_vld_i[k];
                    rd_addr_next[wr_idx] = issue_rd_addr_i[k];
                end
            end
            tail_ptr_next = tail_ptr_reg + issue_cnt[ITAG_WIDTH_P-1:0];
            count_next    = count_reg + issue_cnt - retire_cnt;
        end

        if (flush_i) begin
            vld_next       = '0;
            done_next      = '0;
            rd_vld_next    = '0;
            head_ptr_next  = '0;
            tail_ptr_next  = '0;
            count_next     = '0;
            compl_err_next = 1'b0;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_reg       <= '0;
            done_reg      <= '0;
            rd_vld_reg    <= '0;
            rd_addr_reg   <= '0;
            head_ptr_reg  <= '0;
            tail_ptr_reg  <= '0;
            count_reg     <= '0;
            compl_err_reg <= 1'b0;
        end else begin
            vld_reg       <= vld_next;
            done_reg      <= done_next;
            rd_vld_reg    <= rd_vld_next;
            rd_addr_reg   <= rd_addr_next;
            head_ptr_reg  <= head_ptr_next;
            tail_ptr_reg  <= tail_ptr_next;
            count_reg     <= count_next;
            compl_err_reg <= compl_err_next;
        end
    end

    // Lane valids must form a contiguous run starting at lane 0.
    assert property (@(posedge clk_i) disable iff (rst_i)
        ((issue_vld_i + ISSUE_W_P'(1)) & issue_vld_i) == '0);

endmodule

// File: tb/tb_xrv1_iqueue_mw.sv
// Bench for xrv1_iqueue_mw: directed scenarios plus a randomized run checked
// against an in-order queue model of the instruction window.
module tb_xrv1_iqueue_mw;
    localparam int RFW = 5;
    localparam int ITW = 3;
    localparam int IW  = 2;
    localparam int CW  = 2;
    localparam int RW  = 2;
    localparam int NRS = 2;
    localparam int D   = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                           rst = 1'b1;
    logic                           flush;
    logic [IW-1:0]                  issue_vld;
    logic                           issue_rdy;
    logic [IW-1:0]                  issue_rd_vld;
    logic [IW-1:0][RFW-1:0]         issue_rd_addr;
    logic [IW-1:0][NRS-1:0]         issue_rs_vld;
    logic [IW-1:0][NRS-1:0][RFW-1:0] issue_rs_addr;
    logic [IW-1:0][ITW-1:0]         issue_itag;
    logic [CW-1:0]                  compl_vld;
    logic [CW-1:0][ITW-1:0]         compl_itag;
    logic [RW-1:0]                  retire_vld;
    logic [RW-1:0][ITW-1:0]         retire_itag;
    logic [RW-1:0]                  retire_rd_vld;
    logic [RW-1:0][RFW-1:0]         retire_rd_addr;
    logic [IW-1:0][NRS-1:0][D-1:0]  rs_conflict;
    logic [IW-1:0][NRS-1:0]         rs_bundle_conflict;
    logic [ITW:0]                   count;
    logic                           compl_err;

    xrv1_iqueue_mw #(
        .RF_ADDR_WIDTH_P(RFW), .ITAG_WIDTH_P(ITW), .ISSUE_W_P(IW),
        .COMPL_W_P(CW), .RETIRE_W_P(RW), .NUM_RS_P(NRS)
    ) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .issue_vld_i(issue_vld), .issue_rdy_o(issue_rdy),
        .issue_rd_vld_i(issue_rd_vld), .issue_rd_addr_i(issue_rd_addr),
        .issue_rs_vld_i(issue_rs_vld), .issue_rs_addr_i(issue_rs_addr),
        .issue_itag_o(issue_itag),
        .compl_vld_i(compl_vld), .compl_itag_i(compl_itag),
        .retire_vld_o(retire_vld), .retire_itag_o(retire_itag),
        .retire_rd_vld_o(retire_rd_vld), .retire_rd_addr_o(retire_rd_addr),
        .rs_conflict_o(rs_conflict), .rs_bundle_conflict_o(rs_bundle_conflict),
        .count_o(count), .compl_err_o(compl_err)
    );

    // Reference model: the window as an ordered list of in-flight instructions.
    typedef struct {
        int itag;
        bit rdv;
        int rd;
        bit done;
    } ent_t;

    ent_t q[$];
    int   m_tail;
    bit   m_err;
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic idle();
        flush         = 1'b0;
        issue_vld     = '0;
        issue_rd_vld  = '0;
        issue_rd_addr = '0;
        issue_rs_vld  = '0;
        issue_rs_addr = '0;
        compl_vld     = '0;
        compl_itag    = '0;
    endtask

    function automatic int exp_retire_n();
        int n = 0;
        if (flush) return 0;
        while (n < RW && n < q.size() && q[n].done) n++;
        return n;
    endfunction

    // Advance the model by one clock edge using the inputs presented at that edge.
    task automatic model_update();
        bit   pd [D];
        int   n, cnt, found;
        bit   err, rdy;
        ent_t e;
        if (flush) begin
            q.delete();
            m_tail = 0;
            m_err  = 0;
            $display("[%0t] flush", $time);
            return;
        end
        n   = exp_retire_n();
        rdy = (q.size() <= D - IW);
        err = 0;
        for (int i = 0; i < q.size(); i++) pd[i] = q[i].done;
        for (int c = 0; c < CW; c++) begin
            if (compl_vld[c]) begin
                found = -1;
                for (int i = 0; i < q.size(); i++)
                    if (q[i].itag == int'(compl_itag[c])) found = i;
                if (found >= 0 && !pd[found]) begin
                    e = q[found];
                    e.done = 1;
                    q[found] = e;
                end else begin
                    err = 1;
                end
            end
        end
        repeat (n) void'(q.pop_front());
        cnt = 0;
        if (rdy && issue_vld[0]) begin
            for (int k = 0; k < IW; k++) begin
                if (issue_vld[k]) begin
                    e.itag = (m_tail + k) % D;
                    e.rdv  = issue_rd_vld[k];
                    e.rd   = int'(issue_rd_addr[k]);
                    e.done = 0;
                    q.push_back(e);
                    cnt++;
                end
            end
            m_tail = (m_tail + cnt) % D;
        end
        m_err = err;
        if (cnt > 0 || n > 0)
            $display("[%0t] issued=%0d retired=%0d occupancy=%0d", $time, cnt, n, q.size());
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        m_tail = 0;
        m_err  = 0;
    endtask

    task automatic test_reset();
        do_reset();
        issue_rs_vld = '1;
        #1;
        n_checks++; if (issue_rdy !== 1'b1) $display("FAIL reset_rdy: got %b want 1", issue_rdy); else n_pass++;
        n_checks++; if (retire_vld !== 2'b00) $display("FAIL reset_retire: got %b want 00", retire_vld); else n_pass++;
        n_checks++; if (count !== 4'd0) $display("FAIL reset_count: got %0d want 0", count); else n_pass++;
        n_checks++; if (rs_conflict !== '0) $display("FAIL reset_conflict: got %h want 0", rs_conflict); else n_pass++;
        n_checks++; if (compl_err !== 1'b0) $display("FAIL reset_err: got %b want 0", compl_err); else n_pass++;
        idle();
    endtask

    task automatic test_issue_basic();
        do_reset();
        issue_vld = 2'b11; issue_rd_vld = 2'b11;
        issue_rd_addr[0] = 5'd3; issue_rd_addr[1] = 5'd4;
        #1;
        n_checks++; if (issue_itag[0] !== 3'd0) $display("FAIL basic_itag0: got %0d want 0", issue_itag[0]); else n_pass++;
        n_checks++; if (issue_itag[1] !== 3'd1) $display("FAIL basic_itag1: got %0d want 1", issue_itag[1]); else n_pass++;
        tick(); idle(); #1;
        n_checks++; if (count !== 4'd2) $display("FAIL basic_count: got %0d want 2", count); else n_pass++;
        issue_rs_vld[0][0] = 1'b1; issue_rs_addr[0][0] = 5'd3; #1;
        n_checks++; if (rs_conflict[0][0] !== 8'b0000_0001) $display("FAIL basic_conf_x3: got %b want 00000001", rs_conflict[0][0]); else n_pass++;
        issue_rs_addr[0][0] = 5'd4; #1;
        n_checks++; if (rs_conflict[0][0] !== 8'b0000_0010) $display("FAIL basic_conf_x4: got %b want 00000010", rs_conflict[0][0]); else n_pass++;
        issue_rs_addr[0][0] = 5'd5; #1;
        n_checks++; if (rs_conflict[0][0] !== 8'b0) $display("FAIL basic_conf_x5: got %b want 0", rs_conflict[0][0]); else n_pass++;
        idle();
    endtask

    task automatic test_full_retire();
        do_reset();
        for (int p = 0; p < 4; p++) begin
            issue_vld = 2'b11; issue_rd_vld = 2'b11;
            issue_rd_addr[0] = RFW'(10 + 2*p); issue_rd_addr[1] = RFW'(11 + 2*p);
            tick();
            idle(); #1;
            n_checks++;
            if (count !== 4'(2*p + 2)) $display("FAIL full_fill_count: got %0d want %0d", count, 2*p + 2); else n_pass++;
        end
        n_checks++; if (issue_rdy !== 1'b0) $display("FAIL full_rdy: got %b want 0", issue_rdy); else n_pass++;
        compl_vld = 2'b01; compl_itag[0] = 3'd1;
        tick(); idle(); #1;
        n_checks++; if (retire_vld !== 2'b00) $display("FAIL full_no_retire: got %b want 00", retire_vld); else n_pass++;
        compl_vld = 2'b01; compl_itag[0] = 3'd0;
        tick(); idle(); #1;
        n_checks++; if (retire_vld !== 2'b11) $display("FAIL full_retire_vld: got %b want 11", retire_vld); else n_pass++;
        n_checks++; if (retire_itag[0] !== 3'd0 || retire_itag[1] !== 3'd1)
            $display("FAIL full_retire_itag: got %0d,%0d want 0,1", retire_itag[0], retire_itag[1]); else n_pass++;
        n_checks++; if (retire_rd_addr[0] !== 5'd10 || retire_rd_addr[1] !== 5'd11 || retire_rd_vld !== 2'b11)
            $display("FAIL full_retire_rd: got %0d,%0d vld %b want 10,11 vld 11", retire_rd_addr[0], retire_rd_addr[1], retire_rd_vld); else n_pass++;
        tick(); #1;
        n_checks++; if (count !== 4'd6) $display("FAIL full_count_after: got %0d want 6", count); else n_pass++;
        n_checks++; if (issue_rdy !== 1'b1) $display("FAIL full_rdy_after: got %b want 1", issue_rdy); else n_pass++;
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 7; i++) begin
            issue_vld = 2'b01; issue_rd_vld = 2'b01; issue_rd_addr[0] = RFW'($urandom_range(1, 31));
            tick(); idle();
            compl_vld = 2'b01; compl_itag[0] = ITW'(i);
            tick(); idle();
            tick();
        end
        #1;
        n_checks++; if (count !== 4'd0) $display("FAIL wrap_drain: got %0d want 0", count); else n_pass++;
        issue_vld = 2'b11; issue_rd_vld = 2'b11; issue_rd_addr[0] = 5'd10; issue_rd_addr[1] = 5'd11;
        #1;
        n_checks++; if (issue_itag[0] !== 3'd7 || issue_itag[1] !== 3'd0)
            $display("FAIL wrap_itag: got %0d,%0d want 7,0", issue_itag[0], issue_itag[1]); else n_pass++;
        tick(); idle();
        compl_vld = 2'b11; compl_itag[0] = 3'd7; compl_itag[1] = 3'd0;
        tick(); idle(); #1;
        n_checks++; if (retire_vld !== 2'b11) $display("FAIL wrap_retire_vld: got %b want 11", retire_vld); else n_pass++;
        n_checks++; if (retire_itag[0] !== 3'd7 || retire_itag[1] !== 3'd0)
            $display("FAIL wrap_retire_itag: got %0d,%0d want 7,0", retire_itag[0], retire_itag[1]); else n_pass++;
        n_checks++; if (retire_rd_addr[0] !== 5'd10 || retire_rd_addr[1] !== 5'd11)
            $display("FAIL wrap_retire_rd: got %0d,%0d want 10,11", retire_rd_addr[0], retire_rd_addr[1]); else n_pass++;
        tick(); #1;
        n_checks++; if (count !== 4'd0) $display("FAIL wrap_count: got %0d want 0", count); else n_pass++;
    endtask

    task automatic test_bundle_hazard();
        do_reset();
        issue_vld = 2'b11; issue_rd_vld = 2'b01;
        issue_rd_addr[0] = 5'd5; issue_rd_addr[1] = 5'd9;
        issue_rs_vld[0][0] = 1'b1; issue_rs_addr[0][0] = 5'd5;
        issue_rs_vld[1][0] = 1'b1; issue_rs_addr[1][0] = 5'd5;
        issue_rs_addr[1][1] = 5'd6;
        #1;
        n_checks++; if (rs_bundle_conflict[1][0] !== 1'b1) $display("FAIL bundle_l1: got %b want 1", rs_bundle_conflict[1][0]); else n_pass++;
        n_checks++; if (rs_bundle_conflict[0][0] !== 1'b0) $display("FAIL bundle_l0: got %b want 0", rs_bundle_conflict[0][0]); else n_pass++;
        n_checks++; if (rs_bundle_conflict[1][1] !== 1'b0) $display("FAIL bundle_l1_rs1: got %b want 0", rs_bundle_conflict[1][1]); else n_pass++;
        issue_rd_vld = 2'b00; #1;
        n_checks++; if (rs_bundle_conflict[1][0] !== 1'b0) $display("FAIL bundle_no_rd: got %b want 0", rs_bundle_conflict[1][0]); else n_pass++;
        issue_rd_vld = 2'b01; issue_vld = 2'b00; #1;
        n_checks++; if (rs_bundle_conflict[1][0] !== 1'b0) $display("FAIL bundle_no_vld: got %b want 0", rs_bundle_conflict[1][0]); else n_pass++;
        idle();
    endtask

    task automatic test_compl_err();
        do_reset();
        issue_vld = 2'b11; issue_rd_vld = 2'b11; issue_rd_addr[0] = 5'd1; issue_rd_addr[1] = 5'd2;
        tick(); idle();
        compl_vld = 2'b01; compl_itag[0] = 3'd5;
        tick(); idle(); #1;
        n_checks++; if (compl_err !== 1'b1) $display("FAIL err_invalid: got %b want 1", compl_err); else n_pass++;
        n_checks++; if (count !== 4'd2 || retire_vld !== 2'b00)
            $display("FAIL err_invalid_state: got count %0d retire %b want 2 00", count, retire_vld); else n_pass++;
        tick(); #1;
        n_checks++; if (compl_err !== 1'b0) $display("FAIL err_pulse: got %b want 0", compl_err); else n_pass++;
        compl_vld = 2'b01; compl_itag[0] = 3'd1;
        tick(); idle(); #1;
        n_checks++; if (compl_err !== 1'b0) $display("FAIL err_good: got %b want 0", compl_err); else n_pass++;
        compl_vld = 2'b01; compl_itag[0] = 3'd1;
        tick(); idle(); #1;
        n_checks++; if (compl_err !== 1'b1) $display("FAIL err_done: got %b want 1", compl_err); else n_pass++;
        n_checks++; if (count !== 4'd2 || retire_vld !== 2'b00)
            $display("FAIL err_done_state: got count %0d retire %b want 2 00", count, retire_vld); else n_pass++;
        compl_vld = 2'b11; compl_itag[0] = 3'd0; compl_itag[1] = 3'd0;
        tick(); idle(); #1;
        n_checks++; if (compl_err !== 1'b0) $display("FAIL err_dup_port: got %b want 0", compl_err); else n_pass++;
        n_checks++; if (retire_vld !== 2'b11) $display("FAIL err_dup_retire: got %b want 11", retire_vld); else n_pass++;
        tick();
    endtask

    task automatic test_flush();
        do_reset();
        issue_vld = 2'b11; issue_rd_vld = 2'b11; issue_rd_addr[0] = 5'd1; issue_rd_addr[1] = 5'd2;
        tick();
        issue_rd_addr[0] = 5'd3; issue_rd_addr[1] = 5'd4;
        tick();
        issue_vld = 2'b01; issue_rd_addr[0] = 5'd5;
        compl_vld = 2'b01; compl_itag[0] = 3'd0;
        tick(); idle(); #1;
        n_checks++; if (count !== 4'd5 || retire_vld !== 2'b01)
            $display("FAIL flush_pre: got count %0d retire %b want 5 01", count, retire_vld); else n_pass++;
        flush = 1'b1; issue_vld = 2'b11; issue_rd_vld = 2'b11;
        compl_vld = 2'b01; compl_itag[0] = 3'd1;
        #1;
        n_checks++; if (retire_vld !== 2'b00) $display("FAIL flush_retire_mask: got %b want 00", retire_vld); else n_pass++;
        tick(); idle(); #1;
        n_checks++; if (count !== 4'd0) $display("FAIL flush_count: got %0d want 0", count); else n_pass++;
        n_checks++; if (issue_rdy !== 1'b1) $display("FAIL flush_rdy: got %b want 1", issue_rdy); else n_pass++;
        n_checks++; if (issue_itag[0] !== 3'd0) $display("FAIL flush_itag: got %0d want 0", issue_itag[0]); else n_pass++;
        n_checks++; if (compl_err !== 1'b0 || retire_vld !== 2'b00)
            $display("FAIL flush_quiet: got err %b retire %b want 0 00", compl_err, retire_vld); else n_pass++;
    endtask

    task automatic test_async_reset();
        do_reset();
        issue_vld = 2'b11; issue_rd_vld = 2'b11; issue_rd_addr[0] = 5'd7; issue_rd_addr[1] = 5'd8;
        tick(); idle();
        compl_vld = 2'b11; compl_itag[0] = 3'd0; compl_itag[1] = 3'd6;
        tick(); idle();
        issue_rs_vld[0][0] = 1'b1; issue_rs_addr[0][0] = 5'd7;
        #1;
        n_checks++; if (compl_err !== 1'b1 || retire_vld !== 2'b01 || count !== 4'd2 || rs_conflict[0][0] !== 8'b01)
            $display("FAIL areset_pre: got err %b retire %b count %0d conf %b want 1 01 2 00000001",
                     compl_err, retire_vld, count, rs_conflict[0][0]); else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++; if (count !== 4'd0 || issue_rdy !== 1'b1)
            $display("FAIL areset_count: got count %0d rdy %b want 0 1", count, issue_rdy); else n_pass++;
        n_checks++; if (retire_vld !== 2'b00 || compl_err !== 1'b0)
            $display("FAIL areset_retire: got retire %b err %b want 00 0", retire_vld, compl_err); else n_pass++;
        n_checks++; if (rs_conflict !== '0) $display("FAIL areset_conf: got %h want 0", rs_conflict); else n_pass++;
        q.delete(); m_tail = 0; m_err = 0;
        idle();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_random();
        int n, nsel;
        logic [IW-1:0][NRS-1:0][D-1:0] ec;
        logic [IW-1:0][NRS-1:0]        eb;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            nsel          = $urandom_range(0, 2);
            issue_vld     = IW'((1 << nsel) - 1);
            issue_rd_vld  = IW'($urandom);
            issue_rs_vld  = (IW*NRS)'($urandom);
            for (int k = 0; k < IW; k++) begin
                issue_rd_addr[k] = RFW'($urandom_range(0, 7));
                for (int r = 0; r < NRS; r++) issue_rs_addr[k][r] = RFW'($urandom_range(0, 7));
            end
            for (int c = 0; c < CW; c++) begin
                compl_vld[c] = ($urandom % 3) != 0;
                if (q.size() > 0 && ($urandom % 5) != 0)
                    compl_itag[c] = ITW'(q[$urandom_range(0, q.size() - 1)].itag);
                else
                    compl_itag[c] = ITW'($urandom_range(0, D - 1));
            end
            flush = ($urandom % 50) == 0;
            #1;
            n = exp_retire_n();
            ec = '0;
            eb = '0;
            for (int k = 0; k < IW; k++)
                for (int r = 0; r < NRS; r++) begin
                    if (issue_rs_vld[k][r])
                        foreach (q[i])
                            if (q[i].rdv && q[i].rd == int'(issue_rs_addr[k][r])) ec[k][r][q[i].itag] = 1'b1;
                    for (int j = 0; j < k; j++)
                        if (issue_vld[j] && issue_rd_vld[j] && issue_rd_addr[j] == issue_rs_addr[k][r]) eb[k][r] = 1'b1;
                end
            n_checks++; if (issue_rdy !== (q.size() <= D - IW)) $display("FAIL rnd_rdy: cyc %0d got %b occupancy %0d", cyc, issue_rdy, q.size()); else n_pass++;
            n_checks++; if (count !== 4'(q.size())) $display("FAIL rnd_count: cyc %0d got %0d want %0d", cyc, count, q.size()); else n_pass++;
            n_checks++; if (compl_err !== m_err) $display("FAIL rnd_err: cyc %0d got %b want %b", cyc, compl_err, m_err); else n_pass++;
            for (int k = 0; k < IW; k++) begin
                n_checks++; if (issue_itag[k] !== ITW'((m_tail + k) % D))
                    $display("FAIL rnd_itag: cyc %0d lane %0d got %0d want %0d", cyc, k, issue_itag[k], (m_tail + k) % D); else n_pass++;
            end
            n_checks++; if (retire_vld !== RW'((1 << n) - 1)) $display("FAIL rnd_retire_vld: cyc %0d got %b want %0d slots", cyc, retire_vld, n); else n_pass++;
            for (int s = 0; s < n; s++) begin
                n_checks++;
                if (retire_itag[s] !== ITW'(q[s].itag) || retire_rd_vld[s] !== q[s].rdv || (q[s].rdv && retire_rd_addr[s] !== RFW'(q[s].rd)))
                    $display("FAIL rnd_retire_slot: cyc %0d slot %0d got itag %0d rd %b/%0d want %0d %b/%0d",
                             cyc, s, retire_itag[s], retire_rd_vld[s], retire_rd_addr[s], q[s].itag, q[s].rdv, q[s].rd);
                else n_pass++;
            end
            n_checks++; if (rs_conflict !== ec) $display("FAIL rnd_conflict: cyc %0d got %h want %h", cyc, rs_conflict, ec); else n_pass++;
            n_checks++; if (rs_bundle_conflict !== eb) $display("FAIL rnd_bundle: cyc %0d got %b want %b", cyc, rs_bundle_conflict, eb); else n_pass++;
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_issue_basic();
        test_full_retire();
        test_wrap();
        test_bundle_hazard();
        test_compl_err();
        test_flush();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
